// File: rtl/aidc_lite_sched_pkg.sv
// Shared types and widths for the AIDC-Lite compression-engine scheduler.
package aidc_lite_sched_pkg;

    localparam int LEN_W  = 25;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ZERO_LEN = 2'd1,
        ST_TIMEOUT  = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RETIRE
    } state_e;

endpackage

// File: rtl/aidc_lite_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after 'last', wrapping.
module aidc_lite_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/aidc_lite_comp_sched.sv
// Shares one AIDC-Lite compression engine among NUM_REQ requesters: arbitrate, issue,
// watch the level-type done (with optional watchdog) and return a tagged completion.
module aidc_lite_comp_sched
    import aidc_lite_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 0,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_src_addr_i,
    input  logic [NUM_REQ*32-1:0] req_dst_addr_i,
    input  logic [NUM_REQ*25-1:0] req_len_i,
    output logic [31:0]           eng_src_addr_o,
    output logic [31:0]           eng_dst_addr_o,
    output logic [24:0]           eng_len_o,
    output logic                  eng_start_o,
    input  logic                  eng_done_i,
    output logic                  cpl_valid_o,
    input  logic                  cpl_ready_i,
    output logic [ID_W-1:0]       cpl_id_o,
    output logic [1:0]            cpl_status_o,
    output logic                  busy_o,
    output logic [15:0]           ok_cnt_o
);

    localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit               WD_EN    = (TIMEOUT_CYC > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e            state_q, state_d;
    status_e           status_q, status_d;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx, rr_ptr_q, job_id_q;
    logic [ADDR_W-1:0] sel_src, sel_dst, src_q, dst_q;
    logic [LEN_W-1:0]  sel_len, len_q;
    logic [TMR_W-1:0]  timer_q;
    logic [15:0]       ok_cnt_q;
    logic              take_job, timeout_hit;

    aidc_lite_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req  (req_valid_i),
        .last (rr_ptr_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_src = req_src_addr_i[i*ADDR_W +: ADDR_W];
                sel_dst = req_dst_addr_i[i*ADDR_W +: ADDR_W];
                sel_len = req_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign timeout_hit = WD_EN && (timer_q == TMR_LAST);

    // Exit conditions are tested before the watchdog so a same-cycle done still reports OK.
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        req_ready_o = '0;
        take_job    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (eng_done_i && (|req_valid_i)) begin
                    req_ready_o = gnt;
                    take_job    = 1'b1;
                    if (sel_len == '0) begin
                        state_d  = S_RETIRE;
                        status_d = ST_ZERO_LEN;
                    end else begin
                        state_d  = S_ISSUE;
                        status_d = ST_OK;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!eng_done_i) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d  = S_RETIRE;
                    status_d = ST_TIMEOUT;
                end
            end
            S_WAIT_DONE: begin
                if (eng_done_i) begin
                    state_d  = S_RETIRE;
                    status_d = ST_OK;
                end else if (timeout_hit) begin
                    state_d  = S_RETIRE;
                    status_d = ST_TIMEOUT;
                end
            end
            S_RETIRE: begin
                if (cpl_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Job registers double as the engine operand registers, so they hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            job_id_q <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            timer_q  <= '0;
            ok_cnt_q <= '0;
        end else begin
            if (take_job) begin
                src_q    <= sel_src;
                dst_q    <= sel_dst;
                len_q    <= sel_len;
                job_id_q <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
            if (state_q == S_ISSUE) begin
                timer_q <= '0;
            end else if (((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) && (timer_q != '1)) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            if ((state_q == S_RETIRE) && cpl_ready_i && (status_q == ST_OK)) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
        end
    end

    assign eng_src_addr_o = src_q;
    assign eng_dst_addr_o = dst_q;
    assign eng_len_o      = len_q;
    assign eng_start_o    = (state_q == S_ISSUE);
    assign cpl_valid_o    = (state_q == S_RETIRE);
    assign cpl_id_o       = cpl_valid_o ? job_id_q : '0;
    assign cpl_status_o   = cpl_valid_o ? status_q : ST_OK;
    assign busy_o         = (state_q != S_IDLE);
    assign ok_cnt_o       = ok_cnt_q;

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Bench for aidc_lite_comp_sched: directed table, corner sequences and randomized jobs
// checked against a job-level model of arbitration, latency, status and OK count.
module tb_aidc_lite_comp_sched;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 16;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid_i, req_ready_o;
    logic [NUM_REQ*32-1:0] req_src_addr_i, req_dst_addr_i;
    logic [NUM_REQ*25-1:0] req_len_i;
    logic [31:0]           eng_src_addr_o, eng_dst_addr_o;
    logic [24:0]           eng_len_o;
    logic                  eng_start_o, eng_done_i, cpl_valid_o, cpl_ready_i, busy_o;
    logic [ID_W-1:0]       cpl_id_o;
    logic [1:0]            cpl_status_o;
    logic [15:0]           ok_cnt_o;

    aidc_lite_comp_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i), .req_len_i(req_len_i),
        .eng_src_addr_o(eng_src_addr_o), .eng_dst_addr_o(eng_dst_addr_o), .eng_len_o(eng_len_o),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
        .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i),
        .cpl_id_o(cpl_id_o), .cpl_status_o(cpl_status_o),
        .busy_o(busy_o), .ok_cnt_o(ok_cnt_o)
    );

    always #5 clk = ~clk;

    // Engine model: done drops the cycle after start and stays low for busy_cfg cycles.
    int eng_cnt  = 0;
    int busy_cfg = 1;
    always @(posedge clk) begin
        if (eng_start_o) eng_cnt <= busy_cfg;
        else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    end
    assign eng_done_i = (eng_cnt == 0);

    int          checks = 0;
    int          errors = 0;
    bit          pend [NUM_REQ];
    logic [31:0] src_a [NUM_REQ];
    logic [31:0] dst_a [NUM_REQ];
    logic [24:0] len_a [NUM_REQ];
    int          last_g;
    int          ok_exp;

    typedef struct {
        int                 req;
        logic [31:0]        src;
        logic [31:0]        dst;
        logic [24:0]        len;
        int                 busy;
        int                 cpl_wait;
        logic [NUM_REQ-1:0] late;
        logic [1:0]         status;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid_i[i]             = pend[i];
            req_src_addr_i[32*i +: 32] = src_a[i];
            req_dst_addr_i[32*i +: 32] = dst_a[i];
            req_len_i[25*i +: 25]      = len_a[i];
        end
    endtask

    task automatic new_payload(input int i);
        src_a[i] = $urandom;
        dst_a[i] = $urandom;
        len_a[i] = ($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom_range(1, 33554431));
    endtask

    function automatic int rr_pick(input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_status(input logic [24:0] len, input int busy);
        if (len == 0) return 2'd1;
        if (busy >= TMO) return 2'd2;
        return 2'd0;
    endfunction

    // Cycles from the cycle after the grant to the first cpl_valid cycle.
    function automatic int model_latency(input logic [24:0] len, input int busy);
        if (len == 0) return 0;
        return ((busy + 1 < TMO) ? busy + 1 : TMO) + 1;
    endfunction

    task automatic do_job(input logic [1:0] exp_st, input int busy, input int cpl_wait,
                          input logic [NUM_REQ-1:0] add_after, output int g);
        int exp_g, n, starts, unstable, ready_bad, wait_n;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [31:0] js, jd;
        logic [24:0] jl;
        logic [ID_W-1:0] hid;
        logic [1:0] hst;
        g = -1;
        drive_reqs();
        #1;
        wait_n = 0;
        while (req_ready_o == '0 && wait_n < 400) begin
            step();
            wait_n++;
        end
        if (req_ready_o == '0) begin
            errors++;
            $display("FAIL ready_wait: got no grant, expected one within 400 cycles");
            return;
        end
        exp_g   = rr_pick(last_g);
        exp_rdy = '0;
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        chk("grant_onehot", req_ready_o, exp_rdy);
        chk("grant_engine_idle", eng_done_i, 1);
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready_o[i]) g = i;
        last_g   = exp_g;
        js       = src_a[g];
        jd       = dst_a[g];
        jl       = len_a[g];
        busy_cfg = busy;
        step();
        pend[g] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (add_after[i] && !pend[i]) begin
                new_payload(i);
                pend[i] = 1'b1;
            end
        end
        drive_reqs();
        #1;
        chk("start_at_t1", eng_start_o, (jl != 0));
        chk("eng_src", eng_src_addr_o, js);
        chk("eng_dst", eng_dst_addr_o, jd);
        chk("eng_len", eng_len_o, jl);
        n = 0; starts = 0; unstable = 0; ready_bad = 0;
        while (!cpl_valid_o && n < 300) begin
            if (eng_start_o) starts++;
            if (eng_src_addr_o !== js || eng_dst_addr_o !== jd || eng_len_o !== jl) unstable++;
            if (req_ready_o != '0) ready_bad++;
            step();
            n++;
        end
        chk("cpl_latency", n, model_latency(jl, busy));
        chk("start_pulses", starts, (jl != 0) ? 1 : 0);
        chk("eng_stable", unstable, 0);
        chk("no_ready_in_job", ready_bad, 0);
        chk("cpl_id", cpl_id_o, g);
        chk("cpl_status", cpl_status_o, exp_st);
        hid = cpl_id_o;
        hst = cpl_status_o;
        if (cpl_wait > 0) begin
            cpl_ready_i = 1'b0;
            unstable = 0; ready_bad = 0;
            repeat (cpl_wait) begin
                step();
                if (!cpl_valid_o || cpl_id_o !== hid || cpl_status_o !== hst) unstable++;
                if (req_ready_o != '0) ready_bad++;
            end
            chk("cpl_hold", unstable, 0);
            chk("no_grant_in_stall", ready_bad, 0);
            cpl_ready_i = 1'b1;
        end
        if (exp_st == 2'd0) ok_exp++;
        step();
        chk("cpl_drop", cpl_valid_o, 0);
        chk("busy_idle", busy_o, 0);
        chk("ok_cnt", ok_cnt_o, ok_exp & 16'hFFFF);
        if ((req_valid_i != '0) && eng_done_i) chk("back_to_back_grant", (req_ready_o != '0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int g, busy, wait_n, exp_g;
        int rr_got [6];
        int rr_exp [6];
        logic [1:0] st;
        rr_exp = '{2, 3, 0, 2, 3, 0};
        tbl[0] = '{1, 32'h0000_1000, 32'h0000_8000, 25'd2,          10,  0, 4'b0000, 2'd0};
        tbl[1] = '{0, 32'h0000_2000, 32'h0000_3000, 25'd0,          5,   0, 4'b0000, 2'd1};
        tbl[2] = '{3, 32'hDEAD_0000, 32'hBEEF_0000, 25'd1,          15,  0, 4'b0000, 2'd0};
        tbl[3] = '{2, 32'h1234_5678, 32'h8765_4320, 25'd7,          16,  0, 4'b0000, 2'd2};
        tbl[4] = '{1, 32'hFFFF_FF80, 32'h0000_0080, 25'h1FF_FFFF,   100, 0, 4'b0000, 2'd2};
        tbl[5] = '{0, 32'hA5A5_A500, 32'h5A5A_5A00, 25'd3,          1,  10, 4'b0100, 2'd0};

        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; src_a[i] = '0; dst_a[i] = '0; len_a[i] = '0;
        end
        last_g = NUM_REQ - 1;
        ok_exp = 0;
        rst = 1'b1;
        cpl_ready_i = 1'b1;
        drive_reqs();
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_cpl_valid", cpl_valid_o, 0);
        chk("rst_ok_cnt", ok_cnt_o, 0);
        chk("rst_start", eng_start_o, 0);
        chk("rst_eng_src", eng_src_addr_o, 0);
        chk("rst_eng_len", eng_len_o, 0);
        chk("rst_cpl_status", cpl_status_o, 0);

        // Directed single jobs
        for (int r = 0; r < 6; r++) begin
            src_a[tbl[r].req] = tbl[r].src;
            dst_a[tbl[r].req] = tbl[r].dst;
            len_a[tbl[r].req] = tbl[r].len;
            pend[tbl[r].req]  = 1'b1;
            do_job(tbl[r].status, tbl[r].busy, tbl[r].cpl_wait, tbl[r].late, g);
            chk("tbl_served", g, tbl[r].req);
        end

        // Continuous requesters 0, 2, 3 (2 is already pending from the last row)
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == 0 || i == 3) && !pend[i]) begin
                new_payload(i);
                len_a[i] = 25'd4;
                pend[i]  = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            exp_g = rr_pick(last_g);
            do_job(model_status(len_a[exp_g], 3), 3, 0, 4'b1101, g);
            rr_got[k] = g;
        end
        for (int k = 0; k < 6; k++) chk("rr_order", rr_got[k], rr_exp[k]);

        // Reset during S_WAIT_DONE after granting requester 2
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        new_payload(2);
        len_a[2] = 25'd9;
        pend[2]  = 1'b1;
        drive_reqs();
        #1;
        wait_n = 0;
        while (req_ready_o == '0 && wait_n < 400) begin
            step();
            wait_n++;
        end
        chk("rst_seq_grant", req_ready_o, 4'b0100);
        busy_cfg = 50;
        step();
        pend[2] = 1'b0;
        drive_reqs();
        repeat (4) step();
        chk("rst_seq_in_job", busy_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_cpl_valid", cpl_valid_o, 0);
        chk("midrst_ok_cnt", ok_cnt_o, 0);
        chk("midrst_eng_src", eng_src_addr_o, 0);
        last_g = NUM_REQ - 1;
        ok_exp = 0;
        new_payload(0); pend[0] = 1'b1;
        new_payload(3); pend[3] = 1'b1;
        do_job(model_status(len_a[0], 2), 2, 0, 4'b0000, g);
        chk("midrst_first_winner", g, 0);

        // Randomized jobs against the model
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    new_payload(i);
                    pend[i] = 1'b1;
                end
            end
            if (rr_pick(0) < 0) begin
                g = $urandom_range(0, NUM_REQ - 1);
                new_payload(g);
                pend[g] = 1'b1;
            end
            exp_g = rr_pick(last_g);
            busy  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 30) : $urandom_range(1, 15);
            st    = model_status(len_a[exp_g], busy);
            do_job(st, busy, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 4'b0000, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
